// File: rtl/spi_pkg.sv
// Shared SPI definitions used by the slave port and the master datapath.
// Holds frame-length arithmetic and the slave FSM state encoding.
package spi_pkg;

  localparam int PAD_BITS = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // SCLK cycles in one frame: leading pad bits plus the data bytes
  function automatic int calc_bits(input int bytes);
    return 8 * bytes + PAD_BITS;
  endfunction

endpackage

// File: rtl/spi_sync2.sv
// Two-flop synchroniser for an asynchronous pin, plus a history flop
// so the caller can detect edges on the synchronised signal.
module spi_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic prev
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_reg <= RST_VAL;
      sync_reg <= RST_VAL;
      prev_reg <= RST_VAL;
    end else begin
      meta_reg <= din;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign sync = sync_reg;
  assign prev = prev_reg;

endmodule

// File: rtl/spi_slave_port.sv
// SPI mode-0 slave endpoint: oversamples the pins in the clk domain,
// receives one padded frame and replies with tx_dat captured at select.
module spi_slave_port
  import spi_pkg::*;
#(
  parameter int BYTES = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sclk,
  input  logic               ss_n,
  input  logic               mosi,
  output logic               miso,
  output logic               miso_oe,
  input  logic [8*BYTES-1:0] tx_dat,
  output logic [8*BYTES-1:0] rx_dat,
  output logic               rx_valid,
  output logic               busy,
  output logic               err
);

  localparam int DW   = 8 * BYTES;
  localparam int BITS = calc_bits(BYTES);
  localparam int CW   = $clog2(BITS + 1);

  logic sclk_s, sclk_p;
  logic ss_s, ss_p;
  logic mosi_s, mosi_prev_unused;

  spi_sync2 #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .din(sclk), .sync(sclk_s), .prev(sclk_p)
  );

  // Deselected is the safe power-up value for slave select
  spi_sync2 #(.RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset(reset), .din(ss_n), .sync(ss_s), .prev(ss_p)
  );

  spi_sync2 #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .din(mosi), .sync(mosi_s), .prev(mosi_prev_unused)
  );

  logic sclk_rise, sclk_fall, ss_fall, ss_rise;
  assign sclk_rise = sclk_s & ~sclk_p;
  assign sclk_fall = ~sclk_s & sclk_p;
  assign ss_fall   = ~ss_s & ss_p;
  assign ss_rise   = ss_s & ~ss_p;

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic [DW:0]   tx_sh_reg, tx_sh_next;
  logic [DW-2:0] rx_sh_reg, rx_sh_next;
  logic [DW-1:0] rx_dat_reg, rx_dat_next;
  logic          rx_valid_reg, rx_valid_next;
  logic          err_reg, err_next;
  logic          miso_reg, miso_next;
  logic          ovr_reg, ovr_next;
  logic [DW-1:0] rx_shifted;

  // Only the newest DW bits are kept, so the pad bits fall off the top
  assign rx_shifted = {rx_sh_reg, mosi_s};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      tx_sh_reg    <= '0;
      rx_sh_reg    <= '0;
      rx_dat_reg   <= '0;
      rx_valid_reg <= 1'b0;
      err_reg      <= 1'b0;
      miso_reg     <= 1'b0;
      ovr_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      tx_sh_reg    <= tx_sh_next;
      rx_sh_reg    <= rx_sh_next;
      rx_dat_reg   <= rx_dat_next;
      rx_valid_reg <= rx_valid_next;
      err_reg      <= err_next;
      miso_reg     <= miso_next;
      ovr_reg      <= ovr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    tx_sh_next    = tx_sh_reg;
    rx_sh_next    = rx_sh_reg;
    rx_dat_next   = rx_dat_reg;
    rx_valid_next = 1'b0;
    err_next      = 1'b0;
    miso_next     = miso_reg;
    ovr_next      = ovr_reg;

    case (state_reg)
      IDLE: begin
        if (ss_fall) begin
          // First pad bit is driven now; the second pad leads the shifter
          tx_sh_next = {1'b0, tx_dat};
          miso_next  = 1'b0;
          count_next = '0;
          ovr_next   = 1'b0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          rx_sh_next = rx_shifted[DW-2:0];
          count_next = count_reg + CW'(1);
          if (count_reg == CW'(BITS - 1)) begin
            rx_dat_next   = rx_shifted;
            rx_valid_next = 1'b1;
            miso_next     = 1'b0;
            state_next    = DONE;
          end
        end else if (sclk_fall) begin
          miso_next  = tx_sh_reg[DW];
          tx_sh_next = {tx_sh_reg[DW-1:0], 1'b0};
        end
        // A final rise coinciding with deselect still completes the frame
        if (ss_rise) begin
          if (state_next != DONE) begin
            err_next = 1'b1;
          end
          miso_next  = 1'b0;
          state_next = IDLE;
        end
      end
      DONE: begin
        if (ss_rise) begin
          miso_next  = 1'b0;
          state_next = IDLE;
        end else if (sclk_rise && !ovr_reg) begin
          err_next = 1'b1;
          ovr_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign miso     = miso_reg;
  assign miso_oe  = (state_reg != IDLE);
  assign busy     = (state_reg != IDLE);
  assign rx_dat   = rx_dat_reg;
  assign rx_valid = rx_valid_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_spi_slave_port.sv
// Bench for spi_slave_port: one BYTES=1 and one BYTES=2 instance share
// sclk/mosi; each has its own select so the idle one sees a busy bus.
module tb_spi_slave_port;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        sclk, mosi, ss_n1, ss_n2;
  logic [7:0]  tx1;
  logic [15:0] tx2;
  logic        miso1, oe1, rxv1, busy1, err1;
  logic        miso2, oe2, rxv2, busy2, err2;
  logic [7:0]  rx1;
  logic [15:0] rx2;

  spi_slave_port #(.BYTES(1)) u_dut1 (
    .clk(clk), .reset(reset), .sclk(sclk), .ss_n(ss_n1), .mosi(mosi),
    .miso(miso1), .miso_oe(oe1), .tx_dat(tx1), .rx_dat(rx1),
    .rx_valid(rxv1), .busy(busy1), .err(err1)
  );

  spi_slave_port #(.BYTES(2)) u_dut2 (
    .clk(clk), .reset(reset), .sclk(sclk), .ss_n(ss_n2), .mosi(mosi),
    .miso(miso2), .miso_oe(oe2), .tx_dat(tx2), .rx_dat(rx2),
    .rx_valid(rxv2), .busy(busy2), .err(err2)
  );

  int total = 0;
  int bad = 0;
  int rxv_cnt1 = 0, err_cnt1 = 0, rxv_cnt2 = 0, err_cnt2 = 0;
  logic [15:0] exp_rx1 = '0;
  logic [15:0] exp_rx2 = '0;

  // Pulse counters: one count per clk the output is high
  always @(posedge clk) begin
    if (rxv1) rxv_cnt1++;
    if (err1) err_cnt1++;
    if (rxv2) rxv_cnt2++;
    if (err2) err_cnt2++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one select period of nrises SCLK cycles; captures miso at each rise
  task automatic frame(input int sel, input int nrises, input logic [15:0] data,
                       input int chg_at, input logic [15:0] chg_tx,
                       output logic [31:0] cap);
    int nb;
    logic b;
    nb  = (sel == 1) ? 10 : 18;
    cap = '0;
    if (sel == 1) ss_n1 = 1'b0; else ss_n2 = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nrises; i++) begin
      if (i < 2) b = 1'b0;
      else if (i < nb) b = data[nb - 1 - i];
      else b = 1'($urandom);
      mosi = b;
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      cap = {cap[30:0], (sel == 1) ? miso1 : miso2};
      if (i == chg_at) begin
        if (sel == 1) tx1 = chg_tx[7:0]; else tx2 = chg_tx;
      end
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic deselect(input int sel, input int gap);
    if (sel == 1) ss_n1 = 1'b1; else ss_n2 = 1'b1;
    repeat (3) @(negedge clk);
    check("oe_after_deselect", (sel == 1) ? oe1 : oe2, 1'b0);
    check("busy_after_deselect", (sel == 1) ? busy1 : busy2, 1'b0);
    repeat (gap) @(negedge clk);
  endtask

  // Reference: reply stream is two zero pads then tx MSB first, zeros after;
  // a frame completes iff it saw at least BITS rises; any count != BITS errs.
  task automatic run_and_check(input int sel, input int nrises, input logic [15:0] data,
                               input logic [15:0] txv, input int chg_at,
                               input logic [15:0] chg_tx, input int gap);
    int bits, rv0, e0;
    logic [31:0] cap, exp_cap;
    logic e;
    bits = (sel == 1) ? 10 : 18;
    if (sel == 1) begin tx1 = txv[7:0]; rv0 = rxv_cnt1; e0 = err_cnt1; end
    else begin tx2 = txv; rv0 = rxv_cnt2; e0 = err_cnt2; end
    frame(sel, nrises, data, chg_at, chg_tx, cap);
    exp_cap = '0;
    for (int i = 0; i < nrises; i++) begin
      if (i < 2 || i >= bits) e = 1'b0;
      else e = txv[bits - 1 - i];
      exp_cap = {exp_cap[30:0], e};
    end
    check("miso_stream", cap, exp_cap);
    deselect(sel, gap);
    if (nrises >= bits) begin
      if (sel == 1) exp_rx1 = data & 16'h00ff; else exp_rx2 = data;
    end
    if (sel == 1) begin
      check("rx_valid_pulses", rxv_cnt1 - rv0, (nrises >= bits) ? 1 : 0);
      check("err_pulses", err_cnt1 - e0, (nrises != bits) ? 1 : 0);
      check("rx_dat", {24'h0, rx1}, {16'h0, exp_rx1});
    end else begin
      check("rx_valid_pulses", rxv_cnt2 - rv0, (nrises >= bits) ? 1 : 0);
      check("err_pulses", err_cnt2 - e0, (nrises != bits) ? 1 : 0);
      check("rx_dat", {16'h0, rx2}, {16'h0, exp_rx2});
    end
  endtask

  initial begin
    logic [31:0] cap;
    int rv1, er1, rv2, er2, sel, nr, bits;
    logic [15:0] d, t;

    reset = 1'b0; sclk = 1'b0; mosi = 1'b0; ss_n1 = 1'b1; ss_n2 = 1'b1;
    tx1 = 8'h00; tx2 = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_miso", miso1, 1'b0);
    check("rst_oe", oe1, 1'b0);
    check("rst_busy", busy1, 1'b0);
    check("rst_rx", {24'h0, rx1}, 32'h0);
    check("rst_rx2", {16'h0, rx2}, 32'h0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Idle bus: sclk toggles with both selects high
    rv1 = rxv_cnt1; er1 = err_cnt1; rv2 = rxv_cnt2; er2 = err_cnt2;
    for (int i = 0; i < 6; i++) begin
      mosi = 1'($urandom);
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      check("idle_oe_busy", {oe1, busy1, oe2, busy2}, 4'b0000);
      sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
    check("idle_pulses", rxv_cnt1 + err_cnt1 + rxv_cnt2 + err_cnt2, rv1 + er1 + rv2 + er2);

    // Basic frame: 0xA5 in, 0x3C out
    tx1 = 8'h3C;
    rv1 = rxv_cnt1;
    frame(1, 10, 16'h00A5, -1, 16'h0, cap);
    check("a5_miso_literal", cap, 32'b0000111100);
    deselect(1, 4);
    check("a5_rx", {24'h0, rx1}, 32'hA5);
    check("a5_valid", rxv_cnt1 - rv1, 1);
    exp_rx1 = 16'h00A5;

    // Back-to-back 16-bit frames, tx changed mid-frame 1
    run_and_check(2, 18, 16'h1234, 16'h1111, 6, 16'h2222, 1);
    run_and_check(2, 18, 16'hBEEF, 16'h2222, -1, 16'h0, 4);

    // Short frame, then overrun frame
    run_and_check(1, 6, 16'h0077, 16'h0081, -1, 16'h0, 4);
    run_and_check(1, 12, 16'h00C3, 16'h005E, -1, 16'h0, 4);

    // Reset in the middle of the 5th bit
    rv1 = rxv_cnt1; er1 = err_cnt1;
    tx1 = 8'hFF;
    ss_n1 = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      mosi = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    mosi = 1'b1;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_outputs", {miso1, oe1, rxv1, busy1, err1}, 5'b00000);
    check("midrst_rx", {24'h0, rx1}, 32'h0);
    exp_rx1 = 16'h0000;
    @(negedge clk);
    sclk = 1'b0; ss_n1 = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_no_pulses", (rxv_cnt1 - rv1) + (err_cnt1 - er1), 0);
    run_and_check(1, 10, 16'h005A, 16'h00C6, -1, 16'h0, 4);

    // Randomised frames on either port
    for (int k = 0; k < 8; k++) begin
      sel  = int'($urandom_range(1, 2));
      bits = (sel == 1) ? 10 : 18;
      case ($urandom_range(0, 2))
        0:       nr = bits - int'($urandom_range(1, 4));
        1:       nr = bits;
        default: nr = bits + int'($urandom_range(1, 3));
      endcase
      d = 16'($urandom_range(0, (sel == 1) ? 255 : 65535));
      t = 16'($urandom_range(0, (sel == 1) ? 255 : 65535));
      run_and_check(sel, nr, d, t, -1, 16'h0, int'($urandom_range(2, 6)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
